// File: rtl/st7735_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : st7735_rx_pkg
// Description : Shared command codes, decoder state encoding and the window
//               address-advance helper for the ST7735 SPI receive path.
// Revision    : 1.0 - initial release
// ============================================================================
package st7735_rx_pkg;

   localparam logic [7:0] CMD_CASET = 8'h2A;
   localparam logic [7:0] CMD_RASET = 8'h2B;
   localparam logic [7:0] CMD_RAMWR = 8'h2C;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CASET = 2'd1,
      RASET = 2'd2,
      RAMWR = 2'd3
   } state_t;

   // Step one address inside [lo..hi]; reaching hi wraps back to lo.
   // When lo > hi the value simply increments (8-bit wrap) until it hits hi.
   function automatic logic [7:0] wrap_inc(input logic [7:0] cur,
                                           input logic [7:0] lo,
                                           input logic [7:0] hi);
      return (cur == hi) ? lo : cur + 8'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/st7735_spi_deser.sv
`default_nettype none
// ============================================================================
// Module      : st7735_spi_deser
// Description : Synchronises the 4-wire SPI pins into sys_clk, detects sclk
//               and cs edges, and assembles MSB-first bytes tagged with dc.
//               Flags a cs release that leaves a partial byte behind.
// Revision    : 1.0 - initial release
// ============================================================================
module st7735_spi_deser #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       cs,
   input  logic       dc,
   input  logic       sclk,
   input  logic       mosi,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       byte_is_data,
   output logic       cmd_valid,
   output logic       frame_err
);

   logic [SYNC_STAGES-1:0] r_cs_sync, r_dc_sync, r_sclk_sync, r_mosi_sync;
   logic r_sclk_prev, r_cs_prev, r_sclk_rise, r_cs_rise, r_cs_low;
   logic r_mosi_q, r_dc_q, r_dc_cap;
   logic [2:0] r_bit_cnt;
   logic [6:0] r_shift;
   logic w_bit, w_last;

   // Synchroniser chains for all four asynchronous pins.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_cs_sync   <= '0;
         r_dc_sync   <= '0;
         r_sclk_sync <= '0;
         r_mosi_sync <= '0;
      end else begin
         r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
         r_dc_sync   <= {r_dc_sync[SYNC_STAGES-2:0], dc};
         r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
         r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      end
   end

   // Registered edge detect; r_cs_low stays set on the cs-rise cycle so a bit
   // landing together with the cs release still counts.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_sclk_prev <= 1'b0;
         r_cs_prev   <= 1'b0;
         r_sclk_rise <= 1'b0;
         r_cs_rise   <= 1'b0;
         r_cs_low    <= 1'b0;
         r_mosi_q    <= 1'b0;
         r_dc_q      <= 1'b0;
      end else begin
         r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
         r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
         r_sclk_rise <= r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
         r_cs_rise   <= r_cs_sync[SYNC_STAGES-1] & ~r_cs_prev;
         r_cs_low    <= ~r_cs_prev;
         r_mosi_q    <= r_mosi_sync[SYNC_STAGES-1];
         r_dc_q      <= r_dc_sync[SYNC_STAGES-1];
      end
   end

   assign w_bit  = r_sclk_rise & r_cs_low;
   assign w_last = w_bit & (r_bit_cnt == 3'd7);

   // Bit counter, shift register and registered byte/frame-error strobes.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_bit_cnt    <= 3'd0;
         r_shift      <= 7'd0;
         r_dc_cap     <= 1'b0;
         byte_valid   <= 1'b0;
         byte_data    <= 8'd0;
         byte_is_data <= 1'b0;
         cmd_valid    <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         byte_valid <= w_last;
         cmd_valid  <= w_last & ~r_dc_cap;
         frame_err  <= r_cs_rise & ~w_last & (w_bit | (r_bit_cnt != 3'd0));
         if (w_last) begin
            byte_data    <= {r_shift, r_mosi_q};
            byte_is_data <= r_dc_cap;
         end
         if (w_bit) begin
            r_shift   <= {r_shift[5:0], r_mosi_q};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd0) begin
               r_dc_cap <= r_dc_q;
            end
         end else if (!r_cs_low) begin
            r_bit_cnt <= 3'd0;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/st7735_spi_rx.sv
`default_nettype none
// ============================================================================
// Module      : st7735_spi_rx
// Description : ST7735 SPI receive decoder. Recovers tagged command/data
//               bytes and, when ST7735_RX_PIXEL_EN is defined, tracks the
//               CASET/RASET window and expands RAMWR payloads into addressed
//               RGB565 pixel writes. Without the macro the pixel outputs are 0.
// Revision    : 1.0 - initial release
// ============================================================================
module st7735_spi_rx
   import st7735_rx_pkg::*;
#(
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] X_MAX       = 8'd127,
   parameter logic [7:0] Y_MAX       = 8'd159
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic        cs,
   input  logic        dc,
   input  logic        sclk,
   input  logic        mosi,
   output logic        byte_valid,
   output logic [7:0]  byte_data,
   output logic        byte_is_data,
   output logic        cmd_valid,
   output logic        pix_valid,
   output logic [7:0]  pix_x,
   output logic [7:0]  pix_y,
   output logic [15:0] pix_rgb,
   output logic        frame_err
);

   st7735_spi_deser #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_deser (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .cs           (cs),
      .dc           (dc),
      .sclk         (sclk),
      .mosi         (mosi),
      .byte_valid   (byte_valid),
      .byte_data    (byte_data),
      .byte_is_data (byte_is_data),
      .cmd_valid    (cmd_valid),
      .frame_err    (frame_err)
   );

`ifdef ST7735_RX_PIXEL_EN
   state_t     r_state;
   logic [2:0] r_pcnt;
   logic [7:0] r_lo_start;
   logic [7:0] r_xs, r_xe, r_ys, r_ye;
   logic [7:0] r_cur_x, r_cur_y, r_hi;
   logic       r_have_hi;

   // Decoder FSM: window registers, RAMWR address walk and pixel strobe.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state    <= IDLE;
         r_pcnt     <= 3'd0;
         r_lo_start <= 8'd0;
         r_xs       <= 8'd0;
         r_xe       <= X_MAX;
         r_ys       <= 8'd0;
         r_ye       <= Y_MAX;
         r_cur_x    <= 8'd0;
         r_cur_y    <= 8'd0;
         r_hi       <= 8'd0;
         r_have_hi  <= 1'b0;
         pix_valid  <= 1'b0;
         pix_x      <= 8'd0;
         pix_y      <= 8'd0;
         pix_rgb    <= 16'd0;
      end else begin
         pix_valid <= 1'b0;
         if (byte_valid && !byte_is_data) begin
            // A command always ends the current state; a dangling high byte is dropped.
            r_pcnt    <= 3'd0;
            r_have_hi <= 1'b0;
            case (byte_data)
               CMD_CASET: r_state <= CASET;
               CMD_RASET: r_state <= RASET;
               CMD_RAMWR: begin
                  r_state <= RAMWR;
                  r_cur_x <= r_xs;
                  r_cur_y <= r_ys;
               end
               default:   r_state <= IDLE;
            endcase
         end else if (byte_valid) begin
            case (r_state)
               CASET, RASET: begin
                  // Only the low bytes matter; extra parameters fall past count 4.
                  if (r_pcnt != 3'd4) begin
                     r_pcnt <= r_pcnt + 3'd1;
                  end
                  if (r_pcnt == 3'd1) begin
                     r_lo_start <= byte_data;
                  end
                  if (r_pcnt == 3'd3) begin
                     if (r_state == CASET) begin
                        r_xs <= r_lo_start;
                        r_xe <= byte_data;
                     end else begin
                        r_ys <= r_lo_start;
                        r_ye <= byte_data;
                     end
                  end
               end
               RAMWR: begin
                  if (!r_have_hi) begin
                     r_hi      <= byte_data;
                     r_have_hi <= 1'b1;
                  end else begin
                     r_have_hi <= 1'b0;
                     pix_valid <= 1'b1;
                     pix_x     <= r_cur_x;
                     pix_y     <= r_cur_y;
                     pix_rgb   <= {r_hi, byte_data};
                     r_cur_x   <= wrap_inc(r_cur_x, r_xs, r_xe);
                     if (r_cur_x == r_xe) begin
                        r_cur_y <= wrap_inc(r_cur_y, r_ys, r_ye);
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end
`else
   // Deserialiser-only build: window parameters have no consumer here.
   logic w_unused_cfg;
   assign w_unused_cfg = ^{X_MAX, Y_MAX};
   assign pix_valid    = 1'b0;
   assign pix_x        = 8'd0;
   assign pix_y        = 8'd0;
   assign pix_rgb      = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_st7735_spi_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_st7735_spi_rx
// Description : Directed bench for st7735_spi_rx. Drives the SPI pins at
//               sys_clk/4, queues expected bytes, frame errors and pixels,
//               and compares them as the DUT strobes its outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_st7735_spi_rx;

   localparam int SYNC_STAGES = 2;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        cs = 1'b1;
   logic        dc = 1'b0;
   logic        sclk = 1'b0;
   logic        mosi = 1'b0;
   logic        byte_valid, byte_is_data, cmd_valid, pix_valid, frame_err;
   logic [7:0]  byte_data, pix_x, pix_y;
   logic [15:0] pix_rgb;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int r_edge = 0;

   logic [8:0]  exp_bytes[$];
   logic [31:0] exp_pix[$];
   int          exp_ferr[$];

   st7735_spi_rx #(
      .SYNC_STAGES (SYNC_STAGES),
      .X_MAX       (8'd127),
      .Y_MAX       (8'd159)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst_n    (sys_rst_n),
      .cs           (cs),
      .dc           (dc),
      .sclk         (sclk),
      .mosi         (mosi),
      .byte_valid   (byte_valid),
      .byte_data    (byte_data),
      .byte_is_data (byte_is_data),
      .cmd_valid    (cmd_valid),
      .pix_valid    (pix_valid),
      .pix_x        (pix_x),
      .pix_y        (pix_y),
      .pix_rgb      (pix_rgb),
      .frame_err    (frame_err)
   );

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard side: compare every strobe against the head of its queue.
   always @(negedge sys_clk) begin
      if (sys_rst_n) begin
         if (byte_valid) begin
            if (exp_bytes.size() == 0) begin
               chk("byte_unexpected", {23'd0, byte_is_data, byte_data}, 32'd0);
            end else begin
               logic [8:0] e;
               e = exp_bytes.pop_front();
               chk("byte_data", {24'd0, byte_data}, {24'd0, e[7:0]});
               chk("byte_is_data", {31'd0, byte_is_data}, {31'd0, e[8]});
               chk("cmd_valid", {31'd0, cmd_valid}, {31'd0, ~e[8]});
               chk("byte_latency", cyc - r_edge, SYNC_STAGES + 1);
            end
         end
         if (frame_err) begin
            if (exp_ferr.size() == 0) begin
               chk("frame_err_unexpected", {31'd0, frame_err}, 32'd0);
            end else begin
               void'(exp_ferr.pop_front());
               chk("frame_err_latency", {31'd0, byte_valid}, 32'd0);
            end
         end
         if (pix_valid) begin
            if (exp_pix.size() == 0) begin
               chk("pix_unexpected", {pix_x, pix_y, pix_rgb}, 32'hFFFF_FFFF);
            end else begin
               chk("pixel", {pix_x, pix_y, pix_rgb}, exp_pix.pop_front());
            end
         end
      end
   end

   task automatic expect_pix(input logic [7:0] x, input logic [7:0] y, input logic [15:0] rgb);
`ifdef ST7735_RX_PIXEL_EN
      exp_pix.push_back({x, y, rgb});
`else
      if (x === 8'hxx || y === 8'hxx || rgb === 16'hxxxx) begin
         exp_pix.delete();
      end
`endif
   endtask

   task automatic cs_begin();
      @(negedge sys_clk);
      cs = 1'b0;
      repeat (2) @(negedge sys_clk);
   endtask

   task automatic cs_end();
      @(negedge sys_clk);
      sclk = 1'b0;
      repeat (2) @(negedge sys_clk);
      cs = 1'b1;
      repeat (6) @(negedge sys_clk);
   endtask

   // Shift n bits MSB-first; sclk low 2 cycles then high 2 cycles per bit.
   task automatic send_bits(input logic d, input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         @(negedge sys_clk);
         sclk = 1'b0;
         mosi = b[i];
         dc   = d;
         repeat (2) @(negedge sys_clk);
         sclk = 1'b1;
         if (i == 0) r_edge = cyc + 1;
         @(negedge sys_clk);
      end
   endtask

   task automatic send_byte(input logic d, input logic [7:0] b);
      exp_bytes.push_back({d, b});
      send_bits(d, b, 8);
   endtask

   task automatic do_reset();
      sys_rst_n = 1'b0;
      cs = 1'b1;
      sclk = 1'b0;
      mosi = 1'b0;
      dc = 1'b0;
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (4) @(negedge sys_clk);
   endtask

   initial begin
      // Reset state.
      repeat (3) @(negedge sys_clk);
      chk("reset_bytes", {22'd0, byte_valid, cmd_valid, byte_data}, 32'd0);
      chk("reset_flags", {30'd0, byte_is_data, frame_err}, 32'd0);
      chk("reset_pix", {pix_x, pix_y, pix_rgb}, 32'd0);
      chk("reset_pix_valid", {31'd0, pix_valid}, 32'd0);
      sys_rst_n = 1'b1;
      repeat (4) @(negedge sys_clk);

      // Single command byte.
      cs_begin();
      send_byte(1'b0, 8'h2C);
      cs_end();

      // Window set-up then 6 pixels across a 3x2 window.
      cs_begin();
      send_byte(1'b0, 8'h2A);
      send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h05);
      send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h07);
      send_byte(1'b0, 8'h2B);
      send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h02);
      send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h03);
      send_byte(1'b0, 8'h2C);
      expect_pix(8'd5, 8'd2, 16'hF800); expect_pix(8'd6, 8'd2, 16'hF800);
      expect_pix(8'd7, 8'd2, 16'hF800); expect_pix(8'd5, 8'd3, 16'hF800);
      expect_pix(8'd6, 8'd3, 16'hF800); expect_pix(8'd7, 8'd3, 16'hF800);
      for (int p = 0; p < 6; p++) begin
         send_byte(1'b1, 8'hF8);
         send_byte(1'b1, 8'h00);
      end
      cs_end();

      // Partial byte aborted by cs, then a clean byte.
      cs_begin();
      exp_ferr.push_back(1);
      send_bits(1'b0, 8'hA5, 5);
      cs_end();
      cs_begin();
      send_byte(1'b0, 8'h3A);
      cs_end();

      // Odd RAMWR payload ended by a command; data afterwards is ignored.
      do_reset();
      cs_begin();
      send_byte(1'b0, 8'h2C);
      expect_pix(8'd0, 8'd0, 16'hAABB);
      send_byte(1'b1, 8'hAA); send_byte(1'b1, 8'hBB); send_byte(1'b1, 8'hCC);
      send_byte(1'b0, 8'h00);
      send_byte(1'b1, 8'h11); send_byte(1'b1, 8'h22);
      cs_end();

      // CASET interrupted after 2 params leaves the window untouched.
      do_reset();
      cs_begin();
      send_byte(1'b0, 8'h2A);
      send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h05);
      send_byte(1'b0, 8'h2C);
      expect_pix(8'd0, 8'd0, 16'h1234);
      expect_pix(8'd1, 8'd0, 16'h5678);
      send_byte(1'b1, 8'h12); send_byte(1'b1, 8'h34);
      send_byte(1'b1, 8'h56); send_byte(1'b1, 8'h78);

      // Reset mid-RAMWR and mid-byte.
      send_byte(1'b0, 8'h2C);
      expect_pix(8'd0, 8'd0, 16'h9ABC);
      send_byte(1'b1, 8'h9A); send_byte(1'b1, 8'hBC);
      send_byte(1'b1, 8'hDE);
      repeat (10) @(negedge sys_clk);
      send_bits(1'b1, 8'hF0, 3);
      #3;
      sys_rst_n = 1'b0;
      #1;
      chk("async_rst_bytes", {22'd0, byte_valid, cmd_valid, byte_data}, 32'd0);
      chk("async_rst_flags", {30'd0, byte_is_data, frame_err}, 32'd0);
      chk("async_rst_pix", {pix_x, pix_y, pix_rgb}, 32'd0);
      chk("async_rst_pix_valid", {31'd0, pix_valid}, 32'd0);
      cs = 1'b1;
      sclk = 1'b0;
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      repeat (4) @(negedge sys_clk);
      cs_begin();
      send_byte(1'b0, 8'h2C);
      expect_pix(8'd0, 8'd0, 16'h0102);
      send_byte(1'b1, 8'h01); send_byte(1'b1, 8'h02);
      cs_end();

      // Drain: every queued expectation must have been consumed.
      repeat (20) @(negedge sys_clk);
      chk("bytes_left", exp_bytes.size(), 32'd0);
      chk("pix_left", exp_pix.size(), 32'd0);
      chk("ferr_left", exp_ferr.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
